// File: rtl/imem_sync.sv
// Synchronous instruction memory: registered one-cycle fetch port with ready/hold, word loader, self-clearing INIT.
// Optional IMEM_FAULT_EN macro adds misaligned/out-of-range fetch reporting.
module imem_sync #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic [31:0]      addr_i,
  output logic             ready_o,
  input  logic             hold_i,
  output logic [WIDTH-1:0] inst_o,
  output logic             valid_o,
  output logic             fault_o,
  input  logic             ld_we_i,
  input  logic [31:0]      ld_addr_i,
  input  logic [WIDTH-1:0] ld_data_i
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] inst_q, inst_d;
  logic             valid_q, valid_d, fault_q, fault_d;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic [AW-1:0]    faddr;
  logic             ld_oor, accept;
  logic             unused_bits;

  assign faddr  = addr_i[AW+1:2];
  assign ld_oor = |ld_addr_i[31:AW+2];
  assign accept = req_i && ready_o;
  // Byte-offset bits matter only for fault reporting; upper fetch bits only when faults are enabled.
  assign unused_bits = ^{addr_i[1:0], addr_i[31:AW+2], ld_addr_i[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we      = 1'b0;
    waddr   = cnt_q;
    wdata   = '0;
    ready_o = 1'b0;
    inst_d  = inst_q;
    valid_d = valid_q;
    fault_d = fault_q;
    case (state_q)
      INIT: begin
        we    = 1'b1;
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == LAST) state_d = RUN;
      end
      RUN: begin
        // Loader has priority: any write cycle blocks fetch, so no read-during-write hazard.
        ready_o = !ld_we_i && !hold_i;
        if (ld_we_i && !ld_oor) begin
          we    = 1'b1;
          waddr = ld_addr_i[AW+1:2];
          wdata = ld_data_i;
        end
      end
      default: state_d = INIT;
    endcase
    if (accept) begin
      valid_d = 1'b1;
`ifdef IMEM_FAULT_EN
      inst_d  = (|addr_i[31:AW+2]) ? '0 : mem_q[faddr];
      fault_d = (|addr_i[31:AW+2]) || (|addr_i[1:0]);
`else
      inst_d  = mem_q[faddr];
      fault_d = 1'b0;
`endif
    end else if (!hold_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= INIT;
      cnt_q   <= '0;
      inst_q  <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign inst_o  = inst_q;
  assign valid_o = valid_q;
  assign fault_o = fault_q;
endmodule

// File: doc/imem_sync.md
# imem_sync

Parametrised, synchronous instruction memory for the MIPS core fetch stage. It replaces the combinational `addr -> inst` lookup with a registered one-cycle fetch port that has a ready/valid handshake and a decode-side hold. It adds a word-write loader port, a self-clearing init sequence after reset, and optional fault reporting.

## Interface
- `WIDTH`, 32: instruction/data word width in bits.
- `DEPTH`, 256: number of words. Must be a power of two, ≥ 4. `AW = $clog2(DEPTH)`.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in 1: fetch request.
- `addr` in 32: fetch byte address.
- `ready` out 1: fetch request accepted this cycle when `req && ready`.
- `hold` in 1: decode stall; freezes the output registers.
- `inst` out WIDTH: fetched word, registered.
- `valid` out 1: `inst` holds a fetch result.
- `fault` out 1: the fetch was misaligned or out of range (see Configuration).
- `ld_we` in 1: loader write strobe.
- `ld_addr` in 32: loader byte address. Bits [1:0] are ignored.
- `ld_data` in WIDTH: loader write data.

## Operation
- States: INIT, RUN.
- Reset forces state INIT, clear counter `cnt = 0`, `inst = 0`, `valid = 0`, `fault = 0`.
  - `ready = 0` while in INIT.
- INIT:
  - Each cycle writes `mem[cnt] = 0` and increments `cnt`.
  - When `cnt == DEPTH-1` is written, the next state is RUN.
  - `ld_we` is ignored (the write is dropped). `req` is not accepted.
- RUN: `ready = !ld_we && !hold`.
- Loader (RUN only): `ld_we = 1` writes `mem[ld_addr[AW+1:2]] = ld_data`.
  - If the address is out of range (`ld_addr[31:AW+2] != 0`), the write is dropped.
  - The loader always wins over fetch: during an `ld_we` cycle `ready = 0`, so the requester retries.
- Fetch accept (`req && ready`): on the next edge:
  - `valid = 1`
  - `inst = mem[addr[AW+1:2]]`, or 0 when out of range with `IMEM_FAULT_EN`
  - `fault` per Configuration.
- No accept and `hold = 0`: on the next edge `valid = 0`. `inst` and `fault` retain their values.
- `hold = 1`: `inst`, `valid` and `fault` retain their values. `ready = 0`, so no request is lost.
- Read-during-write to the same word cannot occur, because fetch is blocked in write cycles.
- Reset asserted mid-INIT or mid-RUN restarts INIT from `cnt = 0`. Memory contents are re-cleared.

## Timing
- After `rst` deasserts, INIT lasts exactly DEPTH clock edges. `ready` can first be 1 in the cycle after the DEPTH-th edge.
- Fetch latency is 1 cycle: request at edge n, data and `valid` at edge n+1.
- Throughput is 1 fetch per cycle while `ready` stays high.
- A loader write at edge n is visible to a fetch accepted at edge n+1 or later.
- `ready` is combinational from `ld_we`, `hold` and the state. There is no combinational path from `req` or `addr` to any output.

## Configuration
- `IMEM_FAULT_EN` defined:
  - `fault = 1` if `addr[1:0] != 0` or `addr[31:AW+2] != 0`.
  - Out-of-range fetch returns `inst = 0`.
  - Misaligned in-range fetch returns `mem[addr[AW+1:2]]` with `fault = 1`.
- `IMEM_FAULT_EN` undefined:
  - `fault` is tied to 0.
  - Upper address bits are ignored, so the address wraps modulo DEPTH words.
  - Misalignment is ignored.

## Test plan
- Reset release, DEPTH = 256 -> `ready = 0`, `valid = 0` for exactly 256 edges, then `ready = 1`. A fetch of addr 0x0 returns `inst = 0`.
- Load byte 4 = 127 and byte 40 = 33, then back-to-back fetches of 0, 4, 40 -> `inst` = 0, 127, 33 on consecutive cycles, `valid = 1`, `fault = 0`.
- Fetch addr 400 (word 100, never loaded) -> `inst = 0`.
  - With `IMEM_FAULT_EN`: fetch 1024 -> `inst = 0`, `fault = 1`.
  - Without `IMEM_FAULT_EN`: fetch 1024 -> `mem[0]`, `fault = 0`.
- Same cycle `ld_we` (addr 8, data 0xDEAD) and `req` (addr 8) -> `ready = 0`. The retry next cycle returns `0xDEAD` one cycle later.
- `hold = 1` for 3 cycles while `valid = 1`, `inst = 127` -> the outputs stay frozen and `ready = 0`. After release, the next fetch proceeds normally.
- Assert `rst` at INIT cycle 100 after loading was attempted -> outputs return to 0 immediately. INIT restarts and runs a full 256 cycles. `ld_we` during INIT has no effect: a later fetch of that word returns 0.
